// File: rtl/mc_mem_responder_if.sv
// Request/response bus between the multicycle control path and mc_mem_responder.
// req_be exists only when MEMRESP_BYTE_STROBE_EN is defined.
interface mc_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
`ifdef MEMRESP_BYTE_STROBE_EN
  logic [3:0]  req_be;
`endif
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

`ifdef MEMRESP_BYTE_STROBE_EN
  modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport master (output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err);
`else
  modport slave  (input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport master (output req_valid, req_we, req_addr, req_wdata, rsp_ready,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err);
`endif
endinterface

// File: rtl/mc_mem_responder.sv
// Single-outstanding word memory responder with programmable wait states.
// Optional MEMRESP_BYTE_STROBE_EN enables per-byte write strobes (req_be).
module mc_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic               clk,
  input logic               reset,
  mc_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  we_q;
  logic [31:0]           addr_q;
  logic [31:0]           wdata_q;
`ifdef MEMRESP_BYTE_STROBE_EN
  logic [3:0]            be_q;
`endif
  logic                  accept;
  logic                  commit;
  logic                  addr_err;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           mem [0:(2**ADDR_WIDTH)-1];

  assign idx      = addr_q[ADDR_WIDTH+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_WIDTH + 2)) != '0);

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    accept        = 1'b0;
    commit        = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = !reset;
        if (bus.req_valid) begin
          accept  = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          err_d   = addr_err;
          rdata_d = (addr_err || we_q) ? '0 : mem[idx];
          state_d = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef MEMRESP_BYTE_STROBE_EN
      be_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
`ifdef MEMRESP_BYTE_STROBE_EN
        be_q    <= bus.req_be;
`endif
      end
    end
  end

  // Storage is never reset; a reset landing on the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (commit && we_q && !addr_err && !reset) begin
`ifdef MEMRESP_BYTE_STROBE_EN
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
`else
      mem[idx] <= wdata_q;
`endif
    end
  end

endmodule

// File: tb/tb_mc_mem_responder.sv
// Self-checking bench: two responders (WAIT_CYCLES=2 and 0) against a word-array model.
module tb_mc_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rv;
  logic [1:0]  rr;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic [1:0]  o_rsp_valid;
  logic [1:0]  o_req_ready;
  logic [1:0]  o_err;
  logic [31:0] o_rdata [2];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          wait_of [2];
  logic [31:0] mem_m [2][16];

  always #5 clk = ~clk;

  mc_mem_responder_if ifa ();
  mc_mem_responder_if ifb ();

  assign ifa.req_valid = rv[0];
  assign ifa.rsp_ready = rr[0];
  assign ifa.req_we    = we;
  assign ifa.req_addr  = addr;
  assign ifa.req_wdata = wdata;
  assign ifb.req_valid = rv[1];
  assign ifb.rsp_ready = rr[1];
  assign ifb.req_we    = we;
  assign ifb.req_addr  = addr;
  assign ifb.req_wdata = wdata;
`ifdef MEMRESP_BYTE_STROBE_EN
  assign ifa.req_be = be;
  assign ifb.req_be = be;
`endif

  assign o_rsp_valid = {ifb.rsp_valid, ifa.rsp_valid};
  assign o_req_ready = {ifb.req_ready, ifa.req_ready};
  assign o_err       = {ifb.rsp_err, ifa.rsp_err};
  assign o_rdata[0]  = ifa.rsp_rdata;
  assign o_rdata[1]  = ifb.rsp_rdata;

  mc_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  mc_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction on responder d; hold>0 keeps rsp_ready low for that many RESP cycles.
  task automatic access(input int d, input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] b, input int hold);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          n;
    exp_err = (a[1:0] != 2'b00) || (a >= 32'd1024);
    exp_rd  = '0;
    if (!exp_err && !w) exp_rd = mem_m[d][a[5:2]];
    @(negedge clk);
    chk("req_ready_idle", 32'(o_req_ready[d]), 32'd1);
    we = w; addr = a; wdata = wd; be = b;
    rv[d] = 1'b1;
    rr[d] = (hold == 0);
    @(negedge clk);
    rv[d] = 1'b0;
    n = 0;
    while (o_rsp_valid[d] !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(wait_of[d] + 1));
    chk("rsp_rdata", o_rdata[d], exp_rd);
    chk("rsp_err", 32'(o_err[d]), 32'(exp_err));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        rv[d] = ~rv[d];
        chk("hold_valid", 32'(o_rsp_valid[d]), 32'd1);
        chk("hold_rdata", o_rdata[d], exp_rd);
        chk("hold_err", 32'(o_err[d]), 32'(exp_err));
        chk("hold_req_ready", 32'(o_req_ready[d]), 32'd0);
      end
      rv[d] = 1'b0;
      rr[d] = 1'b1;
    end
    @(negedge clk);
    chk("post_valid", 32'(o_rsp_valid[d]), 32'd0);
    chk("post_rdata", o_rdata[d], 32'd0);
    chk("post_err", 32'(o_err[d]), 32'd0);
    chk("post_req_ready", 32'(o_req_ready[d]), 32'd1);
    rr[d] = 1'b0;
    if (w && !exp_err) begin
`ifdef MEMRESP_BYTE_STROBE_EN
      for (int i = 0; i < 4; i++)
        if (b[i]) mem_m[d][a[5:2]][8*i +: 8] = wd[8*i +: 8];
`else
      mem_m[d][a[5:2]] = wd;
`endif
    end
  endtask

  initial begin
    logic [31:0] ra;
    int          dsel;
    int          kind;
    wait_of[0] = 2;
    wait_of[1] = 0;
    reset = 1'b1; rv = '0; rr = '0; we = 1'b0; addr = '0; wdata = '0; be = 4'hF;

    @(negedge clk);
    @(negedge clk);
    chk("reset_req_ready_a", 32'(o_req_ready[0]), 32'd0);
    chk("reset_req_ready_b", 32'(o_req_ready[1]), 32'd0);
    chk("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 32'(o_req_ready), 32'd3);
    chk("idle_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("idle_rdata_a", o_rdata[0], 32'd0);
    chk("idle_err", 32'(o_err), 32'd0);

    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 16; s++)
        access(d, 1'b1, 32'(s * 4), $urandom, 4'hF, 0);

    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    access(0, 1'b0, 32'h10, 32'h0, 4'hF, 0);
    access(0, 1'b0, 32'h12, 32'h0, 4'hF, 0);
    access(0, 1'b0, 32'h400, 32'h0, 4'hF, 0);
    access(0, 1'b1, 32'h400, 32'h55555555, 4'hF, 0);
    access(0, 1'b1, 32'h3, 32'h66666666, 4'hF, 0);
    access(0, 1'b0, 32'h0, 32'h0, 4'hF, 0);
    access(0, 1'b0, 32'h10, 32'h0, 4'hF, 10);

    access(0, 1'b1, 32'h20, 32'h11111111, 4'hF, 0);
    @(negedge clk);
    we = 1'b1; addr = 32'h20; wdata = 32'h22222222; rv[0] = 1'b1;
    @(negedge clk);
    rv[0] = 1'b0;
    reset = 1'b1;
    chk("rst_wait_req_ready", 32'(o_req_ready[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_wait_valid", 32'(o_rsp_valid[0]), 32'd0);
    chk("rst_wait_rdata", o_rdata[0], 32'd0);
    chk("rst_wait_err", 32'(o_err[0]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_resp", 32'(o_rsp_valid[0]), 32'd0);
      chk("rst_req_ready", 32'(o_req_ready[0]), 32'd1);
    end
    access(0, 1'b0, 32'h20, 32'h0, 4'hF, 0);

    access(1, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, 0);
    access(1, 1'b0, 32'h8, 32'h0, 4'hF, 0);
    access(1, 1'b0, 32'h401, 32'h0, 4'hF, 2);

`ifdef MEMRESP_BYTE_STROBE_EN
    access(0, 1'b1, 32'h30, 32'hAABBCCDD, 4'hF, 0);
    access(0, 1'b1, 32'h30, 32'h11223344, 4'b0101, 0);
    access(0, 1'b0, 32'h30, 32'h0, 4'hF, 0);
    access(0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'b0000, 0);
    access(0, 1'b0, 32'h30, 32'h0, 4'hF, 0);
`endif

    for (int k = 0; k < 150; k++) begin
      dsel = int'($urandom_range(1, 0));
      kind = int'($urandom_range(9, 0));
      ra   = 32'($urandom_range(15, 0)) * 4;
      if (kind == 0) ra = ra | 32'($urandom_range(3, 1));
      else if (kind == 1) ra = ra | (32'd1 << $urandom_range(31, 10));
      access(dsel, 1'($urandom), ra, $urandom, 4'($urandom),
             ($urandom_range(7, 0) == 0) ? int'($urandom_range(4, 1)) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_mem_responder.md
# mc_mem_responder

Word-addressed memory responder that serves the load/store and instruction-fetch requests issued by the multicycle CPU control path. It accepts one request at a time through a valid/ready handshake, models a programmable access latency with a wait-state counter, and returns read data or a write acknowledgement through a second valid/ready handshake. It sits between the control/datapath and the unified instruction/data storage, letting the control FSM stall on memory instead of assuming single-cycle access.

## Interface
- ADDR_WIDTH, 8, word-address bits; array depth is 2^ADDR_WIDTH words of 32 bits
- WAIT_CYCLES, 2, extra wait states per access (0..15)
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_be  in  4  byte write strobes (present only with MEMRESP_BYTE_STROBE_EN)
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts response
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  request was misaligned or out of range

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready: latch we, addr, wdata (and be), load counter with WAIT_CYCLES, go WAIT.
- WAIT: req_ready=0. If counter!=0, decrement. If counter==0: commit access on this edge, go RESP.
- Commit: error if req_addr[1:0]!=0 or any req_addr bit above ADDR_WIDTH+1 is set. Error: no array write, rsp_rdata=0, rsp_err=1. Read: rsp_rdata=mem[addr[ADDR_WIDTH+1:2]]. Write: array updated, rsp_rdata=0.
- RESP: rsp_valid=1, rsp_rdata/rsp_err held stable until rsp_valid&&rsp_ready; then IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- One outstanding request only; req_valid outside IDLE is ignored, not queued.
- Counter 4 bits; WAIT_CYCLES>15 is illegal.

## Timing
- Reset: state IDLE, req_ready=0 during cycle reset is high, then 1; rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0. Array contents not reset.
- Request accepted at edge E -> rsp_valid high after edge E+WAIT_CYCLES+1 (WAIT_CYCLES=0: one cycle).
- Write becomes visible to a read accepted at or after the edge that ends RESP.
- rsp_ready high on first RESP cycle -> IDLE after that edge; next request accepted earliest one cycle later (no back-to-back overlap).
- rsp_ready held low -> RESP indefinitely, outputs constant.
- Reset during WAIT before commit edge: write dropped, array unchanged. Reset in RESP: response discarded.
- Reset has priority over all handshakes in the same cycle.

## Configuration
- MEMRESP_BYTE_STROBE_EN defined: req_be port exists; write updates only bytes with req_be[i]=1 (byte i = bits 8i+7:8i); req_be=0 write still acknowledged, array unchanged.
- Not defined: no req_be port; every non-error write replaces the full word.

## Test plan
- Reset then WAIT_CYCLES=2: write 0xDEADBEEF at 0x10, rsp_ready=1 -> rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0; then read 0x10 -> rsp_rdata=0xDEADBEEF.
- Read 0x12 (misaligned) and 0x400 with ADDR_WIDTH=8 (out of range) -> rsp_err=1, rsp_rdata=0; array at 0x0 unchanged on errored write.
- Hold rsp_ready=0 for 10 cycles in RESP, toggle req_valid -> rsp_valid/rsp_rdata stable, req_ready=0, no new accept; release -> IDLE next cycle.
- Write 0x11111111 to 0x20, then assert reset during WAIT of a write 0x22222222 to 0x20 -> outputs return to reset values, read 0x20 returns 0x11111111.
- WAIT_CYCLES=0: read accepted at edge E -> rsp_valid after edge E+1.
- With MEMRESP_BYTE_STROBE_EN: word 0xAABBCCDD, write 0x11223344 with req_be=4'b0101 -> read returns 0xAA22CC44.
